// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store alignment and sub-word merge between the MEM
// stage and a word-addressed data memory (combinational read, synchronous
// write). Byte/halfword stores run as a two-cycle read-modify-write.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned half/word accesses).
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_rd,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic [31:0]           ld_data,
  output logic                  misalign,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic        load_merge;
  logic        is_byte, is_half, is_word;
  logic        misal, trap;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign is_byte  = (req_size == 2'b00);
  assign is_half  = (req_size == 2'b01);
  assign is_word  = req_size[1];
  assign mem_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  assign misal = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  // Only a request decoded in IDLE can trap; WRITE ignores the request inputs.
  assign trap     = misal && (req_rd || req_wr) && (state_q == IDLE);
  assign misalign = trap;

  // Pick the addressed byte and halfword lanes out of the memory word.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    unique case (req_addr[1:0])
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Build the merged word: memory word with the addressed lane replaced.
  always_comb begin
    merge_d = mem_rdata;
    if (is_byte) begin
      unique case (req_addr[1:0])
        2'd0: merge_d[7:0]   = req_wdata[7:0];
        2'd1: merge_d[15:8]  = req_wdata[7:0];
        2'd2: merge_d[23:16] = req_wdata[7:0];
        2'd3: merge_d[31:24] = req_wdata[7:0];
      endcase
    end else if (req_addr[1]) begin
      merge_d[31:16] = req_wdata[15:0];
    end else begin
      merge_d[15:0] = req_wdata[15:0];
    end
  end

  // State register and merge buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_merge) merge_q <= merge_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = '0;
    ld_data    = '0;
    load_merge = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!trap) begin
          if (req_wr) begin
            if (is_word) begin
              mem_wr    = 1'b1;
              mem_wdata = req_wdata;
            end else begin
              mem_rd     = 1'b1;
              stall      = 1'b1;
              load_merge = 1'b1;
              state_d    = WRITE;
            end
          end else if (req_rd) begin
            mem_rd = 1'b1;
            if (is_byte)
              ld_data = req_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            else if (is_half)
              ld_data = req_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            else
              ld_data = mem_rdata;
          end
        end
      end
      WRITE: begin
        mem_wr    = 1'b1;
        mem_wdata = merge_q;
        state_d   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a word memory drives the DUT,
// while a byte-array reference model predicts loads and memory contents.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_rd, req_wr, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, misalign, mem_rd, mem_wr;
  logic [31:0] ld_data, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem   [64];
  logic [7:0]  mem_b [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .ld_data(ld_data),
    .misalign(misalign), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;

  function automatic logic [31:0] ref_word(input int unsigned idx);
    return {mem_b[4*idx+3], mem_b[4*idx+2], mem_b[4*idx+1], mem_b[4*idx]};
  endfunction

  function automatic logic [31:0] ref_load(input int unsigned n, input logic uns,
                                           input logic [31:0] addr);
    int unsigned base;
    logic [31:0] v;
    base = (int'(addr) % 256) / n * n;
    v = 0;
    for (int unsigned i = 0; i < n; i++) v = v + (32'(mem_b[base+i]) << (8*i));
    if (!uns && n < 4 && ((v >> (8*n-1)) & 1) == 1) v = v - (32'd1 << (8*n));
    return v;
  endfunction

  task automatic ref_store(input int unsigned n, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned base;
    base = (int'(addr) % 256) / n * n;
    for (int unsigned i = 0; i < n; i++) mem_b[base+i] = 8'(wd >> (8*i));
  endtask

  task automatic set_word(input logic [31:0] addr, input logic [31:0] v);
    mem[addr[7:2]] = v;
    for (int unsigned i = 0; i < 4; i++) mem_b[(int'(addr) & 8'hFC) + i] = 8'(v >> (8*i));
  endtask

  task automatic idle_cycle();
    req_rd = 0; req_wr = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    @(negedge clk);
    checks++;
    if ({stall, mem_rd, mem_wr, misalign} !== 4'b0 || ld_data !== 32'd0) begin
      errors++;
      $display("FAIL idle: stall/rd/wr/mis=%b ld=%h want 0000 ld=0", {stall, mem_rd, mem_wr, misalign}, ld_data);
    end
    @(posedge clk); #1;
  endtask

  // One request from posedge+1 to posedge+1; sub-word stores take two cycles.
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input string tag,
                        output logic [31:0] obs_ld);
    int unsigned n, widx;
    logic st, ld, mis, sub;
    logic [31:0] exp_ld;
    n   = sz[1] ? 4 : (sz[0] ? 2 : 1);
    st  = wr;
    ld  = rd & ~wr;
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if ((st | ld) && ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00))) mis = 1'b1;
`endif
    sub    = st & ~mis & (n < 4);
    exp_ld = (ld & ~mis) ? ref_load(n, uns, addr) : 32'd0;
    widx   = int'(addr[7:2]);
    req_rd = rd; req_wr = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    obs_ld = ld_data;
    checks++;
    if (ld_data !== exp_ld) begin errors++; $display("FAIL %s ld_data: got %h want %h", tag, ld_data, exp_ld); end
    checks++;
    if (misalign !== mis) begin errors++; $display("FAIL %s misalign: got %b want %b", tag, misalign, mis); end
    checks++;
    if (stall !== sub) begin errors++; $display("FAIL %s stall: got %b want %b", tag, stall, sub); end
    checks++;
    if (mem_rd !== ((ld | sub) & ~mis)) begin errors++; $display("FAIL %s mem_rd: got %b want %b", tag, mem_rd, (ld | sub) & ~mis); end
    checks++;
    if (mem_wr !== (st & ~sub & ~mis)) begin errors++; $display("FAIL %s mem_wr: got %b want %b", tag, mem_wr, st & ~sub & ~mis); end
    checks++;
    if (mem_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s mem_addr: got %h want %h", tag, mem_addr, {addr[31:2], 2'b00}); end
    if (st && !mis && !sub) begin
      checks++;
      if (mem_wdata !== wd) begin errors++; $display("FAIL %s mem_wdata: got %h want %h", tag, mem_wdata, wd); end
    end
    @(posedge clk); #1;
    if (st && !mis) ref_store(n, addr, wd);
    if (sub) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mem_wr !== 1'b1 || mem_rd !== 1'b0) begin
        errors++; $display("FAIL %s wcycle: stall/wr/rd=%b%b%b want 010", tag, stall, mem_wr, mem_rd);
      end
      checks++;
      if (mem_wdata !== ref_word(widx)) begin errors++; $display("FAIL %s merge: got %h want %h", tag, mem_wdata, ref_word(widx)); end
      @(posedge clk); #1;
    end
    if (st) begin
      checks++;
      if (mem[widx] !== ref_word(widx)) begin errors++; $display("FAIL %s memword: got %h want %h", tag, mem[widx], ref_word(widx)); end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    req_rd = 0; req_wr = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stall, mem_rd, mem_wr, misalign} !== 4'b0 || ld_data !== 32'd0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset: s/r/w/m=%b ld=%h wd=%h want all 0", {stall, mem_rd, mem_wr, misalign}, ld_data, mem_wdata);
    end
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    logic [31:0] o;
    set_word(32'h10, 32'h8899AABB);
    run_op(1, 0, 2'b00, 0, 32'h10, 0, "lb", o);
    checks++; if (o !== 32'hFFFFFFBB) begin errors++; $display("FAIL lb_const: got %h want ffffffbb", o); end
    run_op(1, 0, 2'b00, 1, 32'h10, 0, "lbu", o);
    checks++; if (o !== 32'h000000BB) begin errors++; $display("FAIL lbu_const: got %h want 000000bb", o); end
    run_op(1, 0, 2'b01, 0, 32'h12, 0, "lh", o);
    checks++; if (o !== 32'hFFFF8899) begin errors++; $display("FAIL lh_const: got %h want ffff8899", o); end
    run_op(1, 0, 2'b01, 1, 32'h12, 0, "lhu", o);
    checks++; if (o !== 32'h00008899) begin errors++; $display("FAIL lhu_const: got %h want 00008899", o); end
    run_op(1, 0, 2'b10, 1, 32'h10, 0, "lw", o);
    checks++; if (o !== 32'h8899AABB) begin errors++; $display("FAIL lw_const: got %h want 8899aabb", o); end
    run_op(1, 0, 2'b11, 0, 32'h10, 0, "lw11", o);
    idle_cycle();
  endtask

  task automatic test_subword_store();
    logic [31:0] o;
    set_word(32'h10, 32'h8899AABB);
    run_op(0, 1, 2'b00, 0, 32'h11, 32'h000000CC, "sb", o);
    checks++; if (mem[4] !== 32'h8899CCBB) begin errors++; $display("FAIL sb_const: got %h want 8899ccbb", mem[4]); end
    run_op(0, 1, 2'b01, 0, 32'h12, 32'hFFFF1234, "sh", o);
    run_op(1, 0, 2'b10, 0, 32'h10, 0, "lw_after_sh", o);
    checks++; if (o !== 32'h1234CCBB) begin errors++; $display("FAIL sh_lw: got %h want 1234ccbb", o); end
    set_word(32'h10, 32'h8899AABB);
    run_op(0, 1, 2'b01, 0, 32'h12, 32'hFFFF1234, "sh2", o);
    run_op(1, 0, 2'b10, 0, 32'h10, 0, "lw_after_sh2", o);
    checks++; if (o !== 32'h1234AABB) begin errors++; $display("FAIL sh2_lw: got %h want 1234aabb", o); end
    run_op(1, 1, 2'b00, 0, 32'h13, 32'h000000EE, "rdwr_both", o);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] o;
    run_op(0, 1, 2'b10, 0, 32'h20, 32'hDEADBEEF, "sw20", o);
    run_op(0, 1, 2'b10, 0, 32'h24, 32'h01020304, "sw24", o);
    checks++; if (mem[8] !== 32'hDEADBEEF || mem[9] !== 32'h01020304) begin
      errors++; $display("FAIL sw_b2b: got %h %h want deadbeef 01020304", mem[8], mem[9]);
    end
    run_op(0, 1, 2'b00, 0, 32'h20, 32'h11, "sb_b2b0", o);
    run_op(0, 1, 2'b00, 0, 32'h23, 32'h22, "sb_b2b1", o);
    run_op(0, 1, 2'b01, 0, 32'h26, 32'h3344, "sh_b2b2", o);
    idle_cycle();
  endtask

  task automatic test_reset_mid_rmw();
    set_word(32'h10, 32'h8899AABB);
    req_rd = 0; req_wr = 1; req_size = 2'b00; req_unsigned = 0; req_addr = 32'h10; req_wdata = 32'h55;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_rmw_c0 stall: got %b want 1", stall); end
    @(posedge clk); #1;
    reset = 1;
    req_wr = 0; req_addr = 0; req_wdata = 0;
    #1;
    checks++; if (stall !== 1'b0 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL rst_rmw_out: stall/wr=%b%b want 00", stall, mem_wr);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    checks++; if (mem[4] !== 32'h8899AABB) begin errors++; $display("FAIL rst_rmw_mem: got %h want 8899aabb", mem[4]); end
    idle_cycle();
  endtask

  task automatic test_misalign();
    logic [31:0] o;
    set_word(32'h10, 32'h8899AABB);
    run_op(1, 0, 2'b01, 0, 32'h11, 0, "lh11", o);
`ifdef MISALIGN_TRAP_EN
    checks++; if (o !== 32'd0) begin errors++; $display("FAIL lh11_const: got %h want 00000000", o); end
`else
    checks++; if (o !== 32'hFFFFAABB) begin errors++; $display("FAIL lh11_const: got %h want ffffaabb", o); end
`endif
    run_op(0, 1, 2'b10, 0, 32'h12, 32'h11111111, "sw12", o);
`ifdef MISALIGN_TRAP_EN
    checks++; if (mem[4] !== 32'h8899AABB) begin errors++; $display("FAIL sw12_const: got %h want 8899aabb", mem[4]); end
`else
    checks++; if (mem[4] !== 32'h11111111) begin errors++; $display("FAIL sw12_const: got %h want 11111111", mem[4]); end
`endif
    idle_cycle();
  endtask

  task automatic test_random();
    logic [31:0] o;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) idle_cycle();
      else run_op(1'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom), 1'($urandom),
                  32'($urandom_range(0, 255)), $urandom, "rnd", o);
    end
    idle_cycle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) set_word(32'(4*i), $urandom);
    test_reset();
    test_loads();
    test_subword_store();
    test_back_to_back();
    test_reset_mid_rmw();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store alignment and sub-word merge stage between the CPU MEM pipeline stage and the word-addressed data memory. Turns byte, halfword and word loads/stores into word-aligned memory accesses. Sign- or zero-extends load results. Performs byte and halfword stores as a two-cycle read-modify-write, stalling the pipeline for one cycle. The data memory has a combinational read and a synchronous write.

## Interface
- ADDR_WIDTH, 32, byte address width of request and memory address.

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_rd  in  1  load request from the MEM stage
- req_wr  in  1  store request from the MEM stage; has priority over req_rd
- req_size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word
- req_unsigned  in  1  1 = zero-extend the load result, 0 = sign-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  holds the pipeline; the request must stay stable while this is 1
- ld_data  out  32  extended load result
- misalign  out  1  misaligned-access flag (see Configuration)
- mem_rd  out  1  data memory read enable
- mem_wr  out  1  data memory write enable
- mem_addr  out  ADDR_WIDTH  word-aligned address, {req_addr[ADDR_WIDTH-1:2], 2'b00}
- mem_wdata  out  32  data memory write data
- mem_rdata  in  32  data memory read data, combinational

## Operation
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k]; halfword h occupies bits [16h+15:16h].
- **FSM states:** IDLE and WRITE. Reset sends the FSM to IDLE and clears merge_q (32-bit) to 0.
- **Load in IDLE:** when req_rd=1 and req_wr=0:
  - mem_rd=1.
  - The selected lane from mem_rdata is extended per req_unsigned and driven on ld_data in the same cycle.
  - A word load ignores req_unsigned.
  - stall=0.
- **Word store in IDLE:** mem_wr=1, mem_wdata=req_wdata, stall=0, no state change.
- **Byte or halfword store in IDLE:**
  - Drives mem_rd=1 and mem_wr=0.
  - merge_q is loaded with mem_rdata, with the addressed lane replaced by req_wdata[7:0] or req_wdata[15:0].
  - stall=1; next state is WRITE.
- **WRITE:**
  - Drives mem_wr=1, mem_wdata=merge_q, mem_addr from the (held) req_addr, and stall=0.
  - Request inputs are not decoded, so the held request is not re-triggered.
  - Next state is always IDLE.
- **No request in IDLE:** mem_rd=0, mem_wr=0, ld_data=0, stall=0.
- **req_rd and req_wr both 1:** treated as a store; ld_data=0.
- **Reset mid read-modify-write:** the pending write is dropped, memory is untouched, and the FSM returns to IDLE.

## Timing
- Reset values: stall=0, mem_rd=0, mem_wr=0, misalign=0, ld_data=0, mem_wdata=0; FSM in IDLE.
- Loads: zero added latency; ld_data is valid in the request cycle.
- Word store: commits at the rising edge ending the request cycle.
- Sub-word store: two cycles. Cycle 0 reads the word and asserts stall. Cycle 1 writes, and the write commits at the rising edge ending cycle 1.
- Back-to-back sub-word stores: each takes two cycles with no idle cycle between them.
- A load directly after a sub-word store to the same word returns the merged value, because the write has committed before the load cycle.

## Configuration
- **MISALIGN_TRAP_EN defined:**
  - A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, sets misalign=1 combinationally.
  - For such an access, mem_rd, mem_wr and stall are forced to 0, ld_data=0, and the FSM stays in IDLE.
- **MISALIGN_TRAP_EN not defined:**
  - misalign is tied to 0.
  - Unused low address bits are ignored: a halfword access uses addr[1] only, and a word access ignores addr[1:0].

## Test plan
- **Loads:** memory word 0x10 = 0x8899AABB.
  - lb 0x10 -> ld_data 0xFFFFFFBB.
  - lbu 0x10 -> 0x000000BB.
  - lh 0x12 -> 0xFFFF8899.
  - lhu 0x12 -> 0x00008899.
  - lw 0x10 -> 0x8899AABB.
  - No stall on any of these loads.
- **sb 0x11, wdata 0x000000CC** over 0x8899AABB: stall=1 for exactly one cycle, mem_wr in the second cycle, word becomes 0x8899CCBB.
- **sh 0x12, wdata 0xFFFF1234**, then lw 0x10 in the next cycle: word becomes 0x1234AABB and ld_data = 0x1234AABB.
- **sw 0x20 = 0xDEADBEEF, then sw 0x24 = 0x01020304** on consecutive cycles: stall stays 0 and both words are written.
- **Reset during a sub-word store:** assert reset while in WRITE during sb 0x10 = 0x55 -> word 0x10 is unchanged, stall=0, and the FSM is in IDLE.
- **lh 0x11 and sw 0x12 (data 0x11111111):**
  - With MISALIGN_TRAP_EN: misalign=1, no memory write, ld_data=0.
  - Without MISALIGN_TRAP_EN: lh 0x11 behaves as lh 0x10, and sw 0x12 writes word 0x10.
